if_stage: RTL and testbench

- Instruction-fetch stage of the pipelined CPU.
- Holds the program counter and drives it to the instruction memory.
- Takes back the combinational instruction word and registers it, with PC+4, into the IF/ID pipeline register.
- Supports stall (hazard unit), branch redirect (EX stage) and IF/ID flush.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/pc_register.sv | 45 ++++
 rtl/if_stage.sv | 62 ++++++
 tb/tb_if_stage.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by the fetch stage.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC            = 32'd4;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/pc_register.sv
// Program counter with next-PC selection: branch redirect, hold, or sequential +4.
module pc_register
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_hold,
  input  logic            i_branch,
  input  logic [XLEN-1:0] i_target,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_pc_plus4;

  // Sequential address wraps modulo 2^32 with no overflow indication.
  assign w_pc_plus4 = r_pc + PC_INC;

  // Next-PC mux; a redirect always lands on a word boundary.
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (i_branch) begin
      w_pc_next = {i_target[XLEN-1:2], 2'b00};
    end else if (i_hold) begin
      w_pc_next = r_pc;
    end
  end

  // PC register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc       = r_pc;
  assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives PC to instruction memory and registers the
// returned word with its PC+4 into IF/ID. Redirect beats flush beats stall.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            flush,
  input  logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] if_id_instruction,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic            if_id_valid
);

  localparam if_id_t IF_ID_EMPTY = '{instruction: NOP_INSTR, pc_plus4: '0, valid: 1'b0};

  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_pc_hold;
  logic            w_if_id_clear;
  if_id_t          r_if_id;

  // A redirect overrides stall; a flush alone still honours stall for the PC.
  assign w_pc_hold     = stall && !branch_taken;
  assign w_if_id_clear = branch_taken || flush;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_hold     (w_pc_hold),
    .i_branch   (branch_taken),
    .i_target   (branch_target),
    .o_pc       (w_pc),
    .o_pc_plus4 (w_pc_plus4)
  );

  // IF/ID register: clear on redirect/flush, hold on stall, otherwise capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_id <= IF_ID_EMPTY;
    end else if (w_if_id_clear) begin
      r_if_id <= IF_ID_EMPTY;
    end else if (!stall) begin
      r_if_id <= '{instruction: instruction, pc_plus4: w_pc_plus4, valid: 1'b1};
    end
  end

  assign pc                = w_pc;
  assign if_id_instruction = r_if_id.instruction;
  assign if_id_pc_plus4    = r_if_id.pc_plus4;
  assign if_id_valid       = r_if_id.valid;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed sequence with literal
// expectations, then randomized control against a behavioural fetch model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;

  logic        rand_mode = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;

  if_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall             (stall),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .flush             (flush),
    .instruction       (instruction),
    .pc                (pc),
    .if_id_instruction (if_id_instruction),
    .if_id_pc_plus4    (if_id_pc_plus4),
    .if_id_valid       (if_id_valid)
  );

  always #5 clk = ~clk;

  // Memory contents: directed mode returns base+addr; random mode returns a
  // scrambled word and the out-of-range zero word for the upper half.
  function automatic logic [31:0] mem(input logic [31:0] a, input logic rm);
    if (!rm) return 32'h1000_0000 + a;
    if (a[31]) return 32'h0;
    return {a[15:0] ^ 16'h5a5a, ~a[31:16]};
  endfunction

  assign instruction = mem(pc, rand_mode);

  task automatic model_reset();
    m_pc    = 32'h0;
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
  endtask

  // One clock edge of the fetch stage, from the priority rules.
  task automatic model_edge(input logic b, input logic [31:0] tgt, input logic fl, input logic st);
    if (b) begin
      m_pc    = tgt & 32'hFFFF_FFFC;
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (fl) begin
      if (!st) m_pc = m_pc + 32'd4;
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (!st) begin
      m_instr = mem(m_pc, rand_mode);
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of controls, apply the edge to the model, return at the
  // following falling edge.
  task automatic step(input logic b, input logic [31:0] tgt, input logic fl, input logic st);
    branch_taken  = b;
    branch_target = tgt;
    flush         = fl;
    stall         = st;
    @(posedge clk);
    if (rst_n) model_edge(b, tgt, fl, st);
    @(negedge clk);
  endtask

  task automatic chk_lit(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ins,
                         input logic [31:0] e_pc4, input logic e_v);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".instr"}, if_id_instruction, e_ins);
    chk({tag, ".pc4"}, if_id_pc_plus4, e_pc4);
    chk({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, e_v});
  endtask

  // Compare process: DUT against model on every falling edge.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      chk("cmp.pc", pc, m_pc);
      chk("cmp.instr", if_id_instruction, m_instr);
      chk("cmp.pc4", if_id_pc_plus4, m_pc4);
      chk("cmp.valid", {31'h0, if_id_valid}, {31'h0, m_valid});
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk_lit("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    step(0, 0, 0, 0);
    chk_lit("fetch1", 32'h4, 32'h1000_0000, 32'h4, 1'b1);
    step(0, 0, 0, 0);
    chk_lit("fetch2", 32'h8, 32'h1000_0004, 32'h8, 1'b1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk_lit("stall2", 32'h8, 32'h1000_0004, 32'h8, 1'b1);
    step(0, 0, 0, 0);
    chk_lit("release", 32'hC, 32'h1000_0008, 32'hC, 1'b1);
    step(1, 32'h0000_0043, 0, 0);
    chk_lit("branch", 32'h40, 32'h0, 32'h0, 1'b0);
    step(0, 0, 0, 0);
    chk_lit("after_br", 32'h44, 32'h1000_0040, 32'h44, 1'b1);
    step(1, 32'h20, 0, 1);
    chk_lit("br_stall", 32'h20, 32'h0, 32'h0, 1'b0);
    step(0, 0, 1, 0);
    chk_lit("flush", 32'h24, 32'h0, 32'h0, 1'b0);
    step(0, 0, 1, 1);
    chk_lit("flush_stall", 32'h24, 32'h0, 32'h0, 1'b0);
    step(1, 32'hFFFF_FFFF, 1, 0);
    chk_lit("br_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    step(0, 0, 0, 0);
    chk_lit("wrap", 32'h0, 32'h0FFF_FFFC, 32'h0, 1'b1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);

    // Asynchronous reset in the middle of a stall, with a branch pending.
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
    @(posedge clk);
    model_edge(1'b0, 32'h0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk_lit("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    step(1, 32'h80, 0, 0);
    chk_lit("rst_hold", 32'h0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    chk_lit("restart", 32'h4, 32'h1000_0000, 32'h4, 1'b1);

    // Randomized control traffic.
    rand_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic        rb, rf, rs;
      logic [31:0] rt;
      rb = ($urandom_range(0, 9) == 0);
      rf = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 3) == 0);
      rt = $urandom;
      if ($urandom_range(0, 1) == 0) rt[31] = 1'b0;
      step(rb, rt, rf, rs);
    end
    step(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
